// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge: FSM states,
// HTRANS/HRESP encodings and the three-peripheral address map.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WWAIT  = 2'd1,
        ST_SETUP  = 2'd2,
        ST_ENABLE = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    localparam int NUM_SLV = 3;

    // Element [i] drives Pselx[i].
    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE  = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000};
    localparam logic [NUM_SLV-1:0][31:0] SLV_LIMIT = {32'h8BFF_FFFF, 32'h87FF_FFFF, 32'h83FF_FFFF};

endpackage

// File: rtl/ahb_apb_bridge_decode.sv
// Combinational AHB address-phase qualifier: flags an active in-map transfer
// and produces the one-hot APB peripheral select.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hreadyin,
    output logic              o_valid,
    output logic [2:0]        o_sel
);

    logic w_active;

    assign w_active = i_hreadyin && (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_active && i_haddr >= ADDR_W'(SLV_BASE[i]) && i_haddr <= ADDR_W'(SLV_LIMIT[i]))
                o_sel[i] = 1'b1;
        end
    end

    assign o_valid = |o_sel;

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: captures single transfers and replays
// each as an APB SETUP/ENABLE access, stalling the master meanwhile.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    state_e            r_state;
    state_e            w_next;
    logic              w_valid;
    logic              w_accept;
    logic [2:0]        w_sel;
    logic [2:0]        r_sel;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;

    ahb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .i_haddr    (Haddr),
        .i_htrans   (Htrans),
        .i_hreadyin (Hreadyin),
        .o_valid    (w_valid),
        .o_sel      (w_sel)
    );

    // Transfers are only sampled in the two states where Hreadyout is high.
    assign w_accept = w_valid && (r_state == ST_IDLE || r_state == ST_ENABLE);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ENABLE: w_next = w_accept ? (Hwrite ? ST_WWAIT : ST_SETUP) : ST_IDLE;
            ST_WWAIT:           w_next = ST_SETUP;
            ST_SETUP:           w_next = ST_ENABLE;
            default:            w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_sel    <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else begin
            if (w_accept) begin
                r_sel    <= w_sel;
                r_paddr  <= Haddr;
                r_pwrite <= Hwrite;
            end
            if (r_state == ST_WWAIT) r_pwdata <= Hwdata;
        end
    end

    always_comb begin
        Hreadyout = 1'b1;
        Pselx     = '0;
        Penable   = 1'b0;
        case (r_state)
            ST_WWAIT:  Hreadyout = 1'b0;
            ST_SETUP: begin
                Hreadyout = 1'b0;
                Pselx     = r_sel;
            end
            ST_ENABLE: begin
                Pselx     = r_sel;
                Penable   = 1'b1;
            end
            default: ;
        endcase
    end

    assign Hresp  = HRESP_OKAY;
    assign Hrdata = Prdata;
    assign Pwrite = r_pwrite;
    assign Paddr  = r_paddr;
    assign Pwdata = r_pwdata;

endmodule
